// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester handshakes and FIFO write-port signals shared by the arbiter.
// The slave modport is the arbiter side; master is the producer/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_full;
  logic                        fifo_we;
  logic [DATA_WIDTH-1:0]       fifo_d;
  logic [DATA_WIDTH-1:0]       fifo_mask;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_we, fifo_d, fifo_mask, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_we, fifo_d, fifo_mask, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among N_REQ producers.
// A grant lasts until the grantee's last word or MAX_BURST words, whichever comes first.
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             xfer;
  logic             burst_end;
  logic [N_REQ-1:0] ready;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && v[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    xfer      = 1'b0;
    burst_end = 1'b0;
    ready     = '0;
    if (state_q == GRANT) begin
      ready[grant_id_q] = ~bus.fifo_full;
      xfer      = bus.req_valid[grant_id_q] & ~bus.fifo_full;
      burst_end = xfer & (bus.req_last[grant_id_q] |
                          (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_id_d = rr_pick(bus.req_valid, rr_ptr_q);
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A dropped valid or a full FIFO simply holds everything in place.
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = next_id(grant_id_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Write path is combinational so the FIFO sees the word in the transfer cycle.
  assign bus.req_ready = ready;
  assign bus.fifo_we   = xfer;
  assign bus.fifo_d    = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.fifo_mask = '0;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scenario bench for fifo_write_arbiter: directed cases plus a randomized run
// checked against a burst-level model of round-robin arbitration.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  typedef logic [16:0] word_t;        // {last, data}
  typedef word_t wq_t[$];
  typedef logic [IW+DW-1:0] wr_t;     // {grant_id, data}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus();
  fifo_write_arbiter #(.N_REQ(N), .MAX_BURST(MB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  wq_t          q [N];
  logic [N-1:0] hold;
  logic         full_ctl;
  logic         rst_ctl;

  logic          o_we, o_busy;
  logic [DW-1:0] o_d, o_mask;
  logic [N-1:0]  o_ready, o_valid;
  logic [IW-1:0] o_gid;
  word_t         o_head [N];
  wr_t           wlog[$];

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: present queue heads (unless held), sample outputs mid-cycle, retire transfers.
  task automatic tick();
    logic [N-1:0]    v, l;
    logic [N*DW-1:0] dat;
    @(posedge clk);
    #1;
    v = '0; l = '0; dat = '0;
    for (int i = 0; i < N; i++) begin
      o_head[i] = (q[i].size() > 0) ? q[i][0] : '0;
      if (q[i].size() > 0 && !hold[i]) begin
        v[i] = 1'b1;
        l[i] = q[i][0][16];
        dat[i*DW +: DW] = q[i][0][15:0];
      end
    end
    rst           = rst_ctl;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = dat;
    bus.fifo_full = full_ctl;
    #4;
    o_valid = v;
    o_we    = bus.fifo_we;
    o_d     = bus.fifo_d;
    o_mask  = bus.fifo_mask;
    o_ready = bus.req_ready;
    o_gid   = bus.grant_id;
    o_busy  = bus.busy;
    for (int i = 0; i < N; i++)
      if (v[i] && o_ready[i]) void'(q[i].pop_front());
    if (o_we) wlog.push_back({o_gid, o_d});
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    hold = '0; full_ctl = 1'b0; rst_ctl = 1'b1;
    tick(); tick();
    rst_ctl = 1'b0;
    wlog.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_ready !== 4'b0) begin bad++; $display("FAIL reset_ready: got %b want 0000", o_ready); end
    total++; if (o_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", o_we); end
    total++; if (o_d !== 16'h0) begin bad++; $display("FAIL reset_d: got %h want 0000", o_d); end
    total++; if (o_mask !== 16'h0) begin bad++; $display("FAIL reset_mask: got %h want 0000", o_mask); end
    total++; if (o_gid !== 2'd0) begin bad++; $display("FAIL reset_gid: got %0d want 0", o_gid); end
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back({1'b0, 16'hA000});
    q[0].push_back({1'b0, 16'hA001});
    q[0].push_back({1'b1, 16'hA002});
    tick();
    total++; if (o_busy !== 1'b0 || o_we !== 1'b0) begin
      bad++; $display("FAIL single_idle: got busy=%b we=%b want 0 0", o_busy, o_we); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (o_busy !== 1'b1 || o_we !== 1'b1 || o_d !== 16'hA000 + 16'(k) || o_gid !== 2'd0) begin
        bad++; $display("FAIL single_word%0d: got busy=%b we=%b d=%h gid=%0d want 1 1 %h 0",
                        k, o_busy, o_we, o_d, o_gid, 16'hA000 + 16'(k)); end
    end
    tick();
    total++; if (o_busy !== 1'b0 || o_we !== 1'b0) begin
      bad++; $display("FAIL single_end: got busy=%b we=%b want 0 0", o_busy, o_we); end
    // Pointer now sits at 1, so requester 1 wins over requester 0.
    q[0].push_back({1'b1, 16'hB000});
    q[1].push_back({1'b1, 16'hB100});
    tick(); tick();
    total++; if (o_gid !== 2'd1 || o_we !== 1'b1 || o_d !== 16'hB100) begin
      bad++; $display("FAIL single_rrptr: got gid=%0d we=%b d=%h want 1 1 b100", o_gid, o_we, o_d); end
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    int   nwr;
    int   starts[$];
    logic pb;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 3; b++) begin
        q[i].push_back({1'b0, 16'(i*4096 + b*2)});
        q[i].push_back({1'b1, 16'(i*4096 + b*2 + 1)});
      end
    nwr = 0; pb = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      total++; if (o_busy !== ((t % 3) != 0)) begin
        bad++; $display("FAIL rr_busy_t%0d: got %b want %b", t, o_busy, (t % 3) != 0); end
      if (t < 12 && o_we) nwr++;
      if (o_busy && !pb) starts.push_back(int'(o_gid));
      pb = o_busy;
    end
    total++; if (nwr != 8) begin bad++; $display("FAIL rr_writes: got %0d want 8", nwr); end
    total++; if (starts.size() < 5) begin
      bad++; $display("FAIL rr_grants: got %0d want 5", starts.size()); end
    else for (int k = 0; k < 5; k++) begin
      total++; if (starts[k] != k % N) begin
        bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, starts[k], k % N); end
    end
    total++; if (wlog.size() < 8) begin bad++; $display("FAIL rr_log: got %0d want 8", wlog.size()); end
    else for (int k = 0; k < 8; k++) begin
      wr_t e = {IW'(k/2), 16'((k/2)*4096 + k%2)};
      total++; if (wlog[k] !== e) begin bad++; $display("FAIL rr_data%0d: got %h want %h", k, wlog[k], e); end
    end
  endtask

  task automatic test_burst_cap();
    wr_t exp[$];
    do_reset();
    for (int k = 0; k < 20; k++) q[2].push_back({k == 19, 16'h2000 + 16'(k)});
    q[3].push_back({1'b1, 16'h3000});
    for (int k = 0; k < 16; k++) exp.push_back({2'd2, 16'h2000 + 16'(k)});
    exp.push_back({2'd3, 16'h3000});
    for (int k = 16; k < 20; k++) exp.push_back({2'd2, 16'h2000 + 16'(k)});
    for (int t = 0; t < 26; t++) begin
      tick();
      if (t == 17) begin
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL cap_release: got busy=%b want 0", o_busy); end
      end
    end
    total++; if (wlog.size() != exp.size()) begin
      bad++; $display("FAIL cap_count: got %0d want %0d", wlog.size(), exp.size()); end
    else for (int k = 0; k < exp.size(); k++) begin
      total++; if (wlog[k] !== exp[k]) begin bad++; $display("FAIL cap_word%0d: got %h want %h", k, wlog[k], exp[k]); end
    end
  endtask

  task automatic test_back_pressure();
    logic ew;
    do_reset();
    for (int k = 0; k < 8; k++) q[1].push_back({k == 7, 16'h1000 + 16'(k)});
    for (int t = 0; t < 15; t++) begin
      full_ctl = (t >= 3 && t <= 7);
      tick();
      ew = (t == 1 || t == 2 || (t >= 8 && t <= 13));
      total++; if (o_we !== ew) begin bad++; $display("FAIL bp_we_t%0d: got %b want %b", t, o_we, ew); end
      if (full_ctl) begin
        total++; if (o_ready !== 4'b0) begin bad++; $display("FAIL bp_ready_t%0d: got %b want 0000", t, o_ready); end
      end
    end
    full_ctl = 1'b0;
    total++; if (wlog.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", wlog.size()); end
    else for (int k = 0; k < 8; k++) begin
      total++; if (wlog[k] !== {2'd1, 16'h1000 + 16'(k)}) begin
        bad++; $display("FAIL bp_word%0d: got %h want %h", k, wlog[k], {2'd1, 16'h1000 + 16'(k)}); end
    end
  endtask

  task automatic test_grantee_stall();
    wr_t exp[$];
    do_reset();
    for (int k = 0; k < 5; k++) q[1].push_back({k == 4, 16'h1100 + 16'(k)});
    q[3].push_back({1'b0, 16'h3300});
    q[3].push_back({1'b1, 16'h3301});
    for (int t = 0; t < 13; t++) begin
      hold[1] = (t >= 3 && t <= 5);
      tick();
      if (hold[1]) begin
        total++; if (o_gid !== 2'd1 || o_ready !== 4'b0010 || o_we !== 1'b0 || o_busy !== 1'b1) begin
          bad++; $display("FAIL stall_t%0d: got gid=%0d ready=%b we=%b busy=%b want 1 0010 0 1",
                          t, o_gid, o_ready, o_we, o_busy); end
      end
    end
    hold = '0;
    for (int k = 0; k < 5; k++) exp.push_back({2'd1, 16'h1100 + 16'(k)});
    exp.push_back({2'd3, 16'h3300});
    exp.push_back({2'd3, 16'h3301});
    total++; if (wlog.size() != exp.size()) begin
      bad++; $display("FAIL stall_count: got %0d want %0d", wlog.size(), exp.size()); end
    else for (int k = 0; k < exp.size(); k++) begin
      total++; if (wlog[k] !== exp[k]) begin bad++; $display("FAIL stall_word%0d: got %h want %h", k, wlog[k], exp[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Requester 1 goes first and leaves the pointer at 2.
    q[1].push_back({1'b1, 16'h1111});
    for (int k = 0; k < 5; k++) q[2].push_back({k == 4, 16'h2200 + 16'(k)});
    tick(); tick(); tick(); tick();
    rst_ctl = 1'b1;
    tick();
    rst_ctl = 1'b0;
    total++; if (o_we !== 1'b1 || o_d !== 16'h2201) begin
      bad++; $display("FAIL rstmid_word: got we=%b d=%h want 1 2201", o_we, o_d); end
    q[0].push_back({1'b1, 16'h0A0A});
    tick();
    total++; if (o_busy !== 1'b0 || o_ready !== 4'b0 || o_we !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: got busy=%b ready=%b we=%b want 0 0000 0", o_busy, o_ready, o_we); end
    tick();
    total++; if (o_gid !== 2'd0 || o_we !== 1'b1 || o_d !== 16'h0A0A) begin
      bad++; $display("FAIL rstmid_restart: got gid=%0d we=%b d=%h want 0 1 0a0a", o_gid, o_we, o_d); end
    for (int t = 0; t < 6; t++) tick();
  endtask

  task automatic test_random();
    int           pushed, budget, nb, len;
    bit           m_idle, found, ew;
    int           m_gid, m_ptr, m_cnt, idx;
    logic [N-1:0] er;
    do_reset();
    pushed = 0;
    for (int i = 0; i < N; i++) begin
      nb = $urandom_range(2, 4);
      for (int b = 0; b < nb; b++) begin
        len = $urandom_range(1, 20);
        for (int k = 0; k < len; k++) begin
          q[i].push_back({k == len - 1, 16'($urandom)});
          pushed++;
        end
      end
    end
    m_idle = 1'b1; m_gid = 0; m_ptr = 0; m_cnt = 0; budget = 0;
    while ((any_pending() || !m_idle) && budget < 5000) begin
      for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 4) == 0);
      full_ctl = ($urandom_range(0, 4) == 0);
      tick();
      budget++;
      er = '0;
      if (!m_idle && !full_ctl) er[m_gid] = 1'b1;
      ew = !m_idle && o_valid[m_gid] && !full_ctl;
      total++; if (o_busy !== !m_idle) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", budget, o_busy, !m_idle); end
      total++; if (o_ready !== er) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", budget, o_ready, er); end
      total++; if (o_we !== ew) begin bad++; $display("FAIL rnd_we c%0d: got %b want %b", budget, o_we, ew); end
      if (!m_idle) begin
        total++; if (int'(o_gid) != m_gid) begin bad++; $display("FAIL rnd_gid c%0d: got %0d want %0d", budget, o_gid, m_gid); end
      end
      if (ew && o_we) begin
        total++; if (o_d !== o_head[m_gid][15:0]) begin
          bad++; $display("FAIL rnd_data c%0d: got %h want %h", budget, o_d, o_head[m_gid][15:0]); end
      end
      // Burst-level reference: pick round-robin from idle, end burst on last or cap.
      if (m_idle) begin
        if (o_valid != '0) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && o_valid[idx]) begin m_gid = idx; found = 1'b1; end
          end
          m_idle = 1'b0; m_cnt = 0;
        end
      end else if (ew) begin
        m_cnt++;
        if (o_head[m_gid][16] || m_cnt == MB) begin
          m_idle = 1'b1;
          m_ptr  = (m_gid + 1) % N;
        end
      end
    end
    hold = '0; full_ctl = 1'b0;
    total++; if (budget >= 5000) begin bad++; $display("FAIL rnd_timeout: got %0d cycles want <5000", budget); end
    total++; if (wlog.size() != pushed) begin bad++; $display("FAIL rnd_count: got %0d want %0d", wlog.size(), pushed); end
  endtask

  initial begin
    rst = 1'b1; rst_ctl = 1'b1; hold = '0; full_ctl = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_back_pressure();
    test_grantee_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares the write port of one BRAM-backed FIFO among `N_REQ` producers. Each producer offers 16-bit words with a valid/ready handshake and frames a burst with `req_last`. The arbiter grants one producer at a time for a whole burst, capped at `MAX_BURST` words. It drives the FIFO's `we`, `d` and `mask` directly and back-pressures on `full`. It sits in the FIFO's write-clock domain; the read side is untouched.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum words per grant, 1..255.
- `DATA_WIDTH`, default 16: word width; matches the FIFO data width.
- `clk`  in  1  single clock; the FIFO's `w_clk` is driven from the same net.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester word valid.
- `req_data`  in  N_REQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  N_REQ  marks the final word of requester i's burst.
- `req_ready`  out  N_REQ  one-hot or zero; a word transfers when valid & ready.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_we`  out  1  FIFO write enable.
- `fifo_d`  out  DATA_WIDTH  FIFO write data.
- `fifo_mask`  out  DATA_WIDTH  tied to all-zeros, so all bits are written.
- `grant_id`  out  clog2(N_REQ)  index of the current or last grantee.
- `busy`  out  1  high while in GRANT.

## Operation
- The FSM has two states, IDLE and GRANT. Registers are `state`, `rr_ptr`, `grant_id` and `beat_cnt` (width clog2(MAX_BURST+1)).
- IDLE:
  - If any `req_valid` bit is set, select the first i with `req_valid[i]`, searching upward from `rr_ptr` and wrapping modulo N_REQ.
  - Register `grant_id` = i, `beat_cnt` = 0, and go to GRANT.
  - `req_ready` = 0 and `fifo_we` = 0 throughout IDLE.
- GRANT:
  - `req_ready[grant_id]` = ~fifo_full; all other ready bits are 0.
  - `fifo_we` = req_valid[grant_id] & ~fifo_full.
  - `fifo_d` = req_data slice of grant_id. It is muxed combinationally from the registered `grant_id` and is valid whenever `fifo_we` = 1.
  - Each transfer increments `beat_cnt`.
- Burst end: a transfer with `req_last[grant_id]` = 1, or a transfer where `beat_cnt` == MAX_BURST-1.
  - Next state is IDLE; `rr_ptr` <= (grant_id+1) mod N_REQ.
- Stalls:
  - A grantee deasserting `req_valid` mid-burst holds the grant indefinitely. Nothing transfers and the state is unchanged.
  - `fifo_full` = 1 stalls the burst; no word is lost or duplicated.
- Outside IDLE, `req_last` without `req_valid` is ignored.
- Other requesters are never granted mid-burst, regardless of priority.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0. Outputs: busy 0, req_ready 0, fifo_we 0, fifo_d 0 (the mux selects requester 0 data, gated by we = 0), fifo_mask 0.
- Reset asserted mid-burst: next cycle is IDLE with all registers at their reset values. Any word transferring in the cycle `rst` is high is still written, because `fifo_we` is combinational. Requesters must re-send the burst.
- Arbitration latency: valid seen in IDLE at cycle T gives the grant at T+1, and the first write can occur at T+1.
- Steady state: one word per cycle while valid & ~full.
- Gaps: exactly one dead IDLE cycle between consecutive bursts.
- A single-word burst (last on the first beat) occupies 2 cycles: IDLE then GRANT.
- `fifo_we` and `fifo_full` interact in the same cycle. The FIFO's full flag must already reflect earlier writes; the arbiter never writes when `fifo_full` = 1.

## Test plan
- Reset, single requester: after rst, req_valid=4'b0001 with a 3-word burst 0xA000..0xA002 and last on the third word -> busy rises the next cycle; fifo_we is high for 3 consecutive cycles with d = A000, A001, A002; then IDLE and rr_ptr=1.
- Round-robin fairness: all 4 requesters valid continuously with 2-word bursts -> grant order 0,1,2,3,0; one idle cycle between bursts; 8 writes in 12 cycles.
- Burst cap, MAX_BURST=16: requester 2 streams 20 words with no last -> exactly 16 writes, then the grant passes to the next valid requester; the remaining 4 words are written on requester 2's next grant.
- Back-pressure: fifo_full held high for 5 cycles mid-burst -> fifo_we=0 and req_ready=0 for those cycles; the sequence resumes with no gap or duplicate word.
- Grantee stall: requester 1 drops valid for 3 cycles mid-burst while requester 3 is valid -> the grant stays at 1, requester 3's ready stays 0, and the burst completes after the stall.
- Reset mid-burst: rst pulsed during word 2 of 5 -> next cycle busy=0, req_ready=0, rr_ptr=0; arbitration restarts from requester 0.
